// File: rtl/rh_isa_pkg.sv
// Shared ISA definitions for the issue stage: opcode constants, decode classes,
// the fetch/issue packet types and the immediate-extraction helpers.
package rh_isa_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    typedef enum logic [2:0] {
        ClsR,
        ClsI,
        ClsS,
        ClsB,
        ClsU,
        ClsJ,
        ClsNone
    } op_class_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
    } issue_pkt_t;

    // Map an opcode onto its encoding format; unknown opcodes read and write nothing.
    function automatic op_class_e opc_class(logic [6:0] opc);
        op_class_e cls;
        cls = ClsNone;
        case (opc)
            OpcOp:                      cls = ClsR;
            OpcOpImm, OpcLoad, OpcJalr: cls = ClsI;
            OpcStore:                   cls = ClsS;
            OpcBranch:                  cls = ClsB;
            OpcLui, OpcAuipc:           cls = ClsU;
            OpcJal:                     cls = ClsJ;
            default:                    cls = ClsNone;
        endcase
        return cls;
    endfunction

    // Sign-extended immediate for the given format; R and unknown carry no immediate.
    function automatic logic [XLEN-1:0] imm_of(op_class_e cls, logic [ILEN-1:0] ins);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (cls)
            ClsI: imm = {{20{ins[31]}}, ins[31:20]};
            ClsS: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ClsB: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            ClsU: imm = {ins[31:12], 12'b0};
            ClsJ: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rh_issue_unit_if.sv
// Bundle of the issue stage's fetch, execute, writeback and redirect signals.
// The slave view is the issue unit; the master view is whatever surrounds it.
interface rh_issue_unit_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 32
);
    logic          flush;
    logic          f_valid;
    logic          f_ready;
    logic [AW-1:0] f_pc;
    logic [IW-1:0] f_instr;
    logic          i_valid;
    logic          i_ready;
    logic [AW-1:0] i_pc;
    logic [6:0]    i_opcode;
    logic [4:0]    i_rd;
    logic [4:0]    i_rs1;
    logic [4:0]    i_rs2;
    logic [AW-1:0] i_imm;
    logic          wb_valid;
    logic [4:0]    wb_rd;

    modport slave (
        input  flush, f_valid, f_pc, f_instr, i_ready, wb_valid, wb_rd,
        output f_ready, i_valid, i_pc, i_opcode, i_rd, i_rs1, i_rs2, i_imm
    );

    modport master (
        output flush, f_valid, f_pc, f_instr, i_ready, wb_valid, wb_rd,
        input  f_ready, i_valid, i_pc, i_opcode, i_rd, i_rs1, i_rs2, i_imm
    );

endinterface

// File: rtl/rh_issue_fifo.sv
// Count-based circular buffer of fetch packets. Flush empties it in one cycle
// and wins over any push or pop presented in the same cycle.
module rh_issue_fifo
    import rh_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       push_i,
    input  fetch_pkt_t pkt_i,
    input  logic       pop_i,
    output fetch_pkt_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_pkt_t      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);

    // Local guards keep the count consistent even if a caller ignores full/empty.
    assign push = push_i & ~full_o & ~flush_i;
    assign pop  = pop_i & ~empty_o & ~flush_i;

    // Next pointer/count; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Pointer and occupancy state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observed once count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkt_i;
        end
    end

    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/rh_issue_unit.sv
// In-order issue stage: buffers fetched instructions, decodes the head entry,
// stalls it on a scoreboard RAW hazard and hands it to execute.
module rh_issue_unit
    import rh_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned NREG  = 32
) (
    input logic            clk,
    input logic            rst_n,
    rh_issue_unit_if.slave bus_io
);

    fetch_pkt_t      push_pkt, head;
    logic            fifo_full, fifo_empty;
    logic            push, pop;
    logic            f_ready, i_valid;

    logic [IW-1:0]   head_instr;
    logic [AW-1:0]   head_pc;
    op_class_e       head_cls;
    logic [4:0]      head_rd, head_rs1, head_rs2;
    logic            uses_rs1, uses_rs2, writes_rd;
    logic            hazard;

    logic [NREG-1:0] sb_q, sb_d;

    assign push_pkt = '{pc: bus_io.f_pc, instr: bus_io.f_instr};

    // No pop bypass: a full buffer refuses fetch even while execute drains it.
    assign f_ready = rst_n & ~fifo_full;
    assign push    = bus_io.f_valid & f_ready;
    assign i_valid = rst_n & ~fifo_empty & ~hazard & ~bus_io.flush;
    assign pop     = i_valid & bus_io.i_ready;

    assign bus_io.f_ready = f_ready;
    assign bus_io.i_valid = i_valid;

    rh_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus_io.flush),
        .push_i  (push),
        .pkt_i   (push_pkt),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_instr = head.instr;
    assign head_pc    = head.pc;
    assign head_rd    = head_instr[11:7];
    assign head_rs1   = head_instr[19:15];
    assign head_rs2   = head_instr[24:20];

    // Decode the head entry's register usage from its format.
    always_comb begin
        head_cls  = opc_class(head_instr[6:0]);
        uses_rs1  = head_cls inside {ClsR, ClsI, ClsS, ClsB};
        uses_rs2  = head_cls inside {ClsR, ClsS, ClsB};
        writes_rd = head_cls inside {ClsR, ClsI, ClsU, ClsJ};
        hazard    = (uses_rs1 & sb_q[head_rs1]) | (uses_rs2 & sb_q[head_rs2]);
    end

    // Issue data follows the head; forced to zero in reset and when nothing is buffered.
    always_comb begin
        bus_io.i_pc     = '0;
        bus_io.i_opcode = '0;
        bus_io.i_rd     = '0;
        bus_io.i_rs1    = '0;
        bus_io.i_rs2    = '0;
        bus_io.i_imm    = '0;
        if (rst_n && !fifo_empty) begin
            bus_io.i_pc     = head_pc;
            bus_io.i_opcode = head_instr[6:0];
            bus_io.i_rd     = head_rd;
            bus_io.i_rs1    = head_rs1;
            bus_io.i_rs2    = head_rs2;
            bus_io.i_imm    = imm_of(head_cls, head_instr);
        end
    end

    // Scoreboard update: writeback clears first so a same-cycle issue to the same reg wins.
    always_comb begin
        sb_d = sb_q;
        if (bus_io.wb_valid && bus_io.wb_rd != 5'd0) begin
            sb_d[bus_io.wb_rd] = 1'b0;
        end
        if (pop && writes_rd && head_rd != 5'd0) begin
            sb_d[head_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Scoreboard state; survives flush because in-flight ops still write back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: tb/tb_rh_issue_unit.sv
module tb_rh_issue_unit;

    localparam int unsigned Depth = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rh_issue_unit_if #(.AW(32), .IW(32)) bus ();

    rh_issue_unit #(
        .DEPTH (Depth),
        .IW    (32),
        .AW    (32),
        .NREG  (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    // Reference model: queue of {pc, instr} plus a per-register pending flag.
    logic [63:0] mq[$];
    bit          sb[32];
    bit          exp_fr, exp_iv;

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f,
                             7'h7f};

    // {reads rs1, reads rs2, writes rd}
    function automatic logic [2:0] ref_uses(input logic [6:0] op);
        case (op)
            7'h33:               return 3'b111;
            7'h13, 7'h03, 7'h67: return 3'b101;
            7'h23, 7'h63:        return 3'b110;
            7'h37, 7'h17, 7'h6f: return 3'b001;
            default:             return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic signed [31:0] s;
        logic [31:0]        sgn, t;
        s   = ins;
        sgn = s >>> 31;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin
                t = s >>> 20;
                return t;
            end
            7'h23: begin
                t = s >>> 25;
                return (t << 5) | 32'(ins[11:7]);
            end
            7'h63: return (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
                          | (32'(ins[11:8]) << 1);
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6f: return (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
                          | (32'(ins[30:21]) << 1);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b0, 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] enc_lui(input int rd, input int imm);
        return {20'(imm), 5'(rd), 7'h37};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs against the model; want_* >= 0 adds a directed expectation.
    task automatic check_all(input int want_fr, input int want_iv);
        logic [31:0] pc, ins;
        logic [2:0]  u;
        bit          hz;
        hz = 1'b0;
        pc = '0;
        ins = '0;
        if (mq.size() > 0) begin
            {pc, ins} = mq[0];
            u  = ref_uses(ins[6:0]);
            hz = (u[2] && sb[ins[19:15]]) || (u[1] && sb[ins[24:20]]);
        end
        exp_fr = (rst_n === 1'b1) && (mq.size() < Depth);
        exp_iv = (rst_n === 1'b1) && (mq.size() > 0) && !hz && !bus.flush;
        check("f_ready", 32'(bus.f_ready), 32'(exp_fr));
        check("i_valid", 32'(bus.i_valid), 32'(exp_iv));
        if (want_fr >= 0) check("f_ready_directed", 32'(bus.f_ready), 32'(want_fr));
        if (want_iv >= 0) check("i_valid_directed", 32'(bus.i_valid), 32'(want_iv));
        if (exp_iv) begin
            check("i_pc", bus.i_pc, pc);
            check("i_opcode", 32'(bus.i_opcode), 32'(ins[6:0]));
            check("i_rd", 32'(bus.i_rd), 32'(ins[11:7]));
            check("i_rs1", 32'(bus.i_rs1), 32'(ins[19:15]));
            check("i_rs2", 32'(bus.i_rs2), 32'(ins[24:20]));
            check("i_imm", bus.i_imm, ref_imm(ins));
        end
        if (rst_n === 1'b0) begin
            check("i_data_in_reset",
                  bus.i_pc | bus.i_imm | 32'({bus.i_opcode, bus.i_rd, bus.i_rs1, bus.i_rs2}),
                  32'h0);
        end
    endtask

    // Advance the model across one clock edge using the expectations of this cycle.
    task automatic model_step();
        logic [31:0] pc, ins;
        logic [2:0]  u;
        if (rst_n !== 1'b1) begin
            mq.delete();
            for (int r = 0; r < 32; r++) sb[r] = 1'b0;
        end else begin
            if (bus.wb_valid && bus.wb_rd != 5'd0) sb[bus.wb_rd] = 1'b0;
            if (exp_iv && bus.i_ready) begin
                {pc, ins} = mq.pop_front();
                u = ref_uses(ins[6:0]);
                if (u[0] && ins[11:7] != 5'd0) sb[ins[11:7]] = 1'b1;
            end
            if (bus.flush) mq.delete();
            else if (bus.f_valid && exp_fr) mq.push_back({bus.f_pc, bus.f_instr});
        end
    endtask

    task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ir, input logic wv, input logic [4:0] wr, input logic fl,
                       input int want_fr, input int want_iv);
        bus.f_valid  = fv;
        bus.f_pc     = pc;
        bus.f_instr  = ins;
        bus.i_ready  = ir;
        bus.wb_valid = wv;
        bus.wb_rd    = wr;
        bus.flush    = fl;
        #1;
        check_all(want_fr, want_iv);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input logic ir, input int want_iv);
        cyc(1'b0, 32'h0, 32'h0, ir, 1'b0, 5'd0, 1'b0, -1, want_iv);
    endtask

    task automatic wb(input int rd, input int want_iv);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'(rd), 1'b0, -1, want_iv);
    endtask

    initial begin
        logic [31:0] ins;
        rst_n = 1'b0;

        // Reset held with fetch asserting valid.
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h40 + 32'(k), enc_addi(1, 0, k), 1'b1, 1'b0,
                                       5'd0, 1'b0, 0, 0);
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1, 0);

        // Fill with execute stalled, fifth push held until a pop frees a slot.
        for (int k = 0; k < 4; k++) cyc(1'b1, 32'h1000 + 32'(4 * k), enc_addi(10 + k, 0, k + 1),
                                       1'b0, 1'b0, 5'd0, 1'b0, 1, -1);
        cyc(1'b1, 32'h1010, enc_addi(14, 0, 5), 1'b0, 1'b0, 5'd0, 1'b0, 0, 1);
        cyc(1'b1, 32'h1010, enc_addi(14, 0, 5), 1'b1, 1'b0, 5'd0, 1'b0, 0, 1);
        cyc(1'b1, 32'h1010, enc_addi(14, 0, 5), 1'b1, 1'b0, 5'd0, 1'b0, 1, 1);
        for (int k = 0; k < 5; k++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'(10 + k), 1'b0, -1, -1);

        // RAW stall released the cycle after writeback.
        cyc(1'b1, 32'h100, enc_r(5, 1, 2), 1'b1, 1'b0, 5'd0, 1'b0, -1, 0);
        cyc(1'b1, 32'h104, enc_r(6, 5, 3), 1'b1, 1'b0, 5'd0, 1'b0, -1, 1);
        idle(1'b1, 0);
        idle(1'b1, 0);
        wb(5, 0);
        idle(1'b1, 1);
        wb(6, -1);

        // Issue setting x7 in the same cycle as a writeback to x7: the set wins.
        cyc(1'b1, 32'h200, enc_addi(7, 0, 9), 1'b1, 1'b0, 5'd0, 1'b0, -1, 0);
        cyc(1'b1, 32'h204, enc_r(8, 7, 0), 1'b1, 1'b1, 5'd7, 1'b0, -1, 1);
        idle(1'b1, 0);
        idle(1'b1, 0);
        wb(7, 0);
        idle(1'b1, 1);
        wb(8, -1);

        // Writes to x0 never create a hazard.
        cyc(1'b1, 32'h300, enc_lui(0, 20'h12345), 1'b1, 1'b0, 5'd0, 1'b0, -1, 0);
        cyc(1'b1, 32'h304, enc_r(1, 0, 0), 1'b1, 1'b0, 5'd0, 1'b0, -1, 1);
        idle(1'b1, 1);
        wb(1, -1);

        // Flush with three buffered entries while x4 is pending.
        cyc(1'b1, 32'h400, enc_addi(4, 0, 3), 1'b1, 1'b0, 5'd0, 1'b0, -1, 0);
        cyc(1'b1, 32'h404, enc_addi(0, 0, 1), 1'b1, 1'b0, 5'd0, 1'b0, -1, 1);
        cyc(1'b1, 32'h408, enc_addi(0, 0, 2), 1'b0, 1'b0, 5'd0, 1'b0, -1, 1);
        cyc(1'b1, 32'h40c, enc_addi(0, 0, 3), 1'b0, 1'b0, 5'd0, 1'b0, -1, 1);
        cyc(1'b1, 32'h410, enc_addi(0, 0, 4), 1'b1, 1'b0, 5'd0, 1'b1, 1, 0);
        cyc(1'b1, 32'h500, enc_r(9, 4, 0), 1'b1, 1'b0, 5'd0, 1'b0, 1, 0);
        idle(1'b1, 0);
        wb(4, 0);
        idle(1'b1, 1);
        wb(9, -1);

        // Reset mid-operation drops buffered entries.
        cyc(1'b1, 32'h600, enc_addi(0, 0, 1), 1'b0, 1'b0, 5'd0, 1'b0, -1, -1);
        cyc(1'b1, 32'h604, enc_addi(0, 0, 2), 1'b0, 1'b0, 5'd0, 1'b0, -1, 1);
        rst_n = 1'b0;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 0, 0);
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1, 0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            ins        = $urandom();
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            rst_n      = ($urandom_range(0, 199) != 0);
            cyc(1'($urandom_range(0, 1)), $urandom(), ins, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 39) == 0), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
